btn_event_ctrl: RTL
===================

Name: btn_event_ctrl

Overview:
- Front-end controller for the processor's push-button inputs.
- Per button: synchronises the raw input, debounces it with a stability counter, and detects the press edge.
- Queues one pending event per button and shares the single processor event port between buttons with a round-robin arbiter and a valid/ack handshake.
- Sits between the board buttons and the processor's input peripheral, replacing per-button edge detectors wired directly to the core.

Parameters:
- N_BTN, 4, number of button inputs (2..16).
- DB_CYCLES, 16, consecutive cycles the synchronised input must differ from the debounced state before that state changes (>=2).
- IDW, $clog2(N_BTN), width of evt_id.
- REPEAT_CYCLES, 1000000, hold time between auto-repeat events. Used only with BTN_AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  N_BTN  raw asynchronous button levels, 1 = pressed.
- evt_valid  output  1  an event is offered to the processor.
- evt_id  output  IDW  index of the offered button; stable while evt_valid=1.
- evt_ack  input  1  processor consumes the offered event (sampled only while evt_valid=1).
- pending  output  N_BTN  per-button pending-event flags (status readback).
- ovf  output  1  sticky: a press arrived while that button's event was still pending.
- ovf_clr  input  1  clears ovf.

Behaviour:
- Reset (sync, rst=1 at posedge) clears:
  - synchronisers, debounce counters, debounced state st[], st_d[] and pending[];
  - evt_valid=0, evt_id=0, ovf=0;
  - FSM to IDLE, last_grant=N_BTN-1, so button 0 has first priority.
- Reset mid-handshake drops the offered event and all pending events without any ack.
- A button still held when reset ends debounces from st=0 and produces one fresh event.
- Synchroniser: 2 flops per bit; s[i] is the second-flop output.
- Debounce, per i, counter width clog2(DB_CYCLES):
  - s[i]==st[i]: counter <= 0.
  - Otherwise, if counter==DB_CYCLES-1: st[i] <= s[i] and counter <= 0.
  - Otherwise: counter increments.
  - Result: a change is accepted after exactly DB_CYCLES consecutive differing cycles; shorter glitches are rejected and the counter restarts.
- Edge detect: st_d <= st each cycle; rise[i] = st[i] & ~st_d[i]. Releases generate nothing.
- Pending, per i, at each posedge:
  - rise[i]=1: pending[i] <= 1. Rise wins over a same-cycle ack clear.
  - else if ack clears i: pending[i] <= 0.
  - rise[i]=1 while pending[i]=1 and i is not being cleared that cycle: ovf <= 1.
  - ovf_clr=1: ovf <= 0, unless a new overflow occurs the same cycle (set wins).
- Arbiter FSM:
  - IDLE:
    - If pending != 0, select the first set bit searching from (last_grant+1) mod N_BTN upward with wrap.
    - Register it into evt_id, set evt_valid <= 1, go to OFFER.
    - evt_ack is ignored in IDLE.
  - OFFER:
    - evt_valid and evt_id held.
    - On evt_ack=1: clear pending[evt_id] (subject to the rise-wins rule), evt_valid <= 0, last_grant <= evt_id, go to IDLE.
  - Throughput: at most one event per 2 cycles.
  - Pending bits set while in OFFER wait for the next arbitration.
- Latency, counting edge 1 as the first posedge sampling btn_in=1:
  - s=1 after edge 2;
  - st=1 after edge DB_CYCLES+2;
  - pending set at edge DB_CYCLES+3;
  - evt_valid=1 after edge DB_CYCLES+4.
- pending output equals the internal flags directly, no extra delay.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- When defined:
  - Each button has a hold counter (width clog2(REPEAT_CYCLES+1)), cleared whenever st[i]=0 or rise[i]=1.
  - While st[i]=1, the counter increments. When it reaches REPEAT_CYCLES it produces a one-cycle repeat pulse, ORed into rise[i] with the same pending/ovf rules, and reloads to 0.
- When undefined: no hold counters exist; exactly one event per debounced press.

Test Plan:
- N_BTN=4, DB_CYCLES=4. btn_in[2] high from edge 1, evt_ack tied high → evt_valid high after edge 8 with evt_id=2; cleared after the next edge; pending=0000; no further events while held.
- btn_in[1] high for 3 cycles, then low → no state change, evt_valid stays 0. The same pulse held for 4 cycles → exactly one event, evt_id=1.
- btn 0 and btn 2 pressed the same cycle, ack given 1 cycle after each valid → events offered in order id 0 then id 2; last_grant=2.
- Then buttons 1 and 3 pressed together → order id 3 then id 1 (wrap from last_grant=2).
- btn 1 pressed, released, pressed again (each phase 10 cycles), evt_ack held 0 → ovf=1 after the second debounced press and one event id=1 held. Ack → single delivery. ovf_clr → ovf=0.
- rst asserted 1 cycle while evt_valid=1 with btn 3 held → next cycle evt_valid=0, pending=0000, ovf=0; id=3 re-offered DB_CYCLES+4 edges after rst deasserts.
- With BTN_AUTOREPEAT_EN, REPEAT_CYCLES=20, btn 0 held 70 cycles, acking each event → 4 events with id=0 (initial + 3 repeats).

Source files
------------

// File: rtl/btn_event_ctrl.sv
// Push-button front end: per-button 2-flop sync, counter debounce and press-edge detect,
// one pending event per button, round-robin arbitration onto a single valid/ack event port.
// Optional auto-repeat while a button is held: define BTN_AUTOREPEAT_EN.
module btn_event_ctrl #(
    parameter int N_BTN         = 4,
    parameter int DB_CYCLES     = 16,
    parameter int IDW           = $clog2(N_BTN),
    parameter int REPEAT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic             evt_valid,
    output logic [IDW-1:0]   evt_id,
    input  logic             evt_ack,
    output logic [N_BTN-1:0] pending,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    if (N_BTN < 2 || N_BTN > 16) begin : g_bad_n_btn
        $error("btn_event_ctrl: N_BTN must be in 2..16");
    end
    if (DB_CYCLES < 2) begin : g_bad_db_cycles
        $error("btn_event_ctrl: DB_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat_cycles
        $error("btn_event_ctrl: REPEAT_CYCLES must be >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] st_q, st_d;
    logic [N_BTN-1:0] st_prev_q, st_prev_d;
    logic [CW-1:0]    db_cnt_q [N_BTN];
    logic [CW-1:0]    db_cnt_d [N_BTN];
    logic [N_BTN-1:0] pending_q, pending_d;
    logic             ovf_q, ovf_d;
    state_t           state_q, state_d;
    logic             evt_valid_q, evt_valid_d;
    logic [IDW-1:0]   evt_id_q, evt_id_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;

    logic [N_BTN-1:0] edge_rise;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] ack_clr;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;

    // Synchroniser and debounce: a new level is accepted only after DB_CYCLES
    // consecutive cycles of disagreement; any agreeing cycle restarts the count.
    always_comb begin
        sync1_d   = btn_in;
        sync2_d   = sync1_q;
        st_d      = st_q;
        st_prev_d = st_q;
        for (int i = 0; i < N_BTN; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != st_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    st_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign edge_rise = st_q & ~st_prev_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int HW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_CYCLES);

    logic [HW-1:0]    hold_q [N_BTN];
    logic [HW-1:0]    hold_d [N_BTN];
    logic [N_BTN-1:0] rep_pulse;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            rep_pulse[i] = st_q[i] && (hold_q[i] == REP_LAST);
            if (!st_q[i] || edge_rise[i] || rep_pulse[i]) begin
                hold_d[i] = '0;
            end else begin
                hold_d[i] = hold_q[i] + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            hold_q[i] <= rst ? '0 : hold_d[i];
        end
    end

    assign rise = edge_rise | rep_pulse;
`else
    assign rise = edge_rise;
`endif

    // Pending flags: a rise always wins over a same-cycle ack clear.
    always_comb begin
        ack_clr = '0;
        if (state_q == OFFER && evt_ack) begin
            ack_clr[evt_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~ack_clr) | rise;
        if (|(rise & pending_q & ~ack_clr)) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Round-robin pick: first pending button after the last one granted, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            if (!grant_found && pending_q[(int'(last_grant_q) + k) % N_BTN]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(last_grant_q) + k) % N_BTN);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        evt_valid_d  = evt_valid_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    evt_id_d    = grant_idx;
                    evt_valid_d = 1'b1;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (evt_ack) begin
                    evt_valid_d  = 1'b0;
                    last_grant_d = evt_id_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            st_q         <= '0;
            st_prev_q    <= '0;
            pending_q    <= '0;
            ovf_q        <= 1'b0;
            state_q      <= IDLE;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            last_grant_q <= IDW'(N_BTN - 1);
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            st_q         <= st_d;
            st_prev_q    <= st_prev_d;
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule
